matrix_parser: RTL and testbench
================================

Name: matrix_parser

Overview:
- Receive-side counterpart of the matrix display path: consumes ASCII bytes from the UART receiver and parses whitespace-separated decimal numbers (0–511).
- Writes each parsed number into matrix storage in row-major order (index = r*matrix_col + c) until matrix_row*matrix_col elements are stored.
- Sits between uart_rx and the 25-entry matrix storage; driven by the top-level input-mode controller through a start/busy/done handshake.

Parameters:
- DATA_W, 9, element width in bits (max value 2^DATA_W - 1 = 511).
- MAX_DIM, 5, maximum rows and columns; storage depth MAX_DIM*MAX_DIM = 25.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- start  in  1  level request; begins a parse on rising detection in IDLE.
- matrix_row  in  3  row count, 1..5.
- matrix_col  in  3  column count, 1..5.
- rx_valid  in  1  one-cycle strobe, rx_data valid. At most one byte per cycle.
- rx_data  in  8  received ASCII byte.
- busy  out  1  parse in progress.
- done  out  1  one-cycle pulse when the last element has been written.
- error  out  1  sticky parse error; cleared on next accepted start.
- wr_en  out  1  one-cycle storage write strobe.
- wr_addr  out  5  row-major element index, 0..24.
- wr_data  out  9  parsed value.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters r/c 0, accumulator 0.
- Byte classes:
  - digit: 0x30–0x39.
  - separator: 0x20 (space), 0x0A (LF), 0x0D (CR).
  - anything else: illegal.
- IDLE:
  - busy = 0; rx_valid is ignored.
  - On start = 1: clear r, c, accumulator and error.
  - If matrix_row or matrix_col is 0 or >5: go to ERR. Otherwise busy <= 1 and go to SKIP.
- SKIP:
  - Separator: stay.
  - Digit: acc <= digit, go to ACC.
  - Illegal byte: go to ERR.
- ACC:
  - Digit: acc <= acc*10 + digit. Compute in 13 bits, since the max intermediate is 511*10 + 9. Leading zeros are legal.
  - Separator: terminates the element. In the next cycle wr_en = 1, wr_addr = r*matrix_col + c (evaluated at full width, then truncated to 5 bits), wr_data = acc[8:0]. Fixed latency: one cycle from the terminating rx_valid to wr_en.
  - Advance c. At c == matrix_col - 1: set c <= 0 and advance r. If this was the final element (r == matrix_row - 1 and c == matrix_col - 1), go to FIN. Otherwise go to SKIP.
  - Illegal byte: go to ERR.
- Overflow: if a digit would make acc > 511, go to ERR with no write.
- A byte arriving in the same cycle as wr_en is processed normally. The parser never drops a byte while busy.
- FIN: done = 1 for one cycle, busy <= 0, go to WAIT_REL.
- ERR: error <= 1, busy <= 0, no further writes, go to WAIT_REL. Elements already written remain in storage.
- WAIT_REL: ignore all rx bytes; when start == 0, go to IDLE. This prevents retrigger while start is held high.
- Bytes after the final terminator are ignored until the next start.
- The final element must be followed by a separator. Without one, no write occurs and the block stays busy.
- rst_n low mid-parse: immediate return to IDLE, all outputs 0. No partial write is issued.

Optional Feature:
- MATRIX_PARSER_SATURATE_EN
- Defined: overflow does not error. acc clamps at 511 and further digits of that element are absorbed, so wr_data = 511 on terminate.
- Undefined: overflow goes to ERR as specified above.

Decomposition:
- Shared package (matrix_pkg) holds:
  - ASCII constants: ASCII_0, ASCII_9, ASCII_SPACE, ASCII_LF, ASCII_CR.
  - DATA_W and MAX_DIM.
  - The parser state encoding, shared with matrix_displayer's encoding style.
- One natural sub-module: ascii_decimal_accum.
  - Contents: digit classification, acc*10 + d, overflow/saturate logic, clear/load controls.
  - Everything else (FSM, r/c counters, address generation) stays in matrix_parser.

Test Plan:
- 2x3, bytes "1 2 3\n4 5 6\n" -> six wr_en pulses, addr 0..5 with data 1..6; done one cycle after the write of 6; error = 0.
- 1x2, "511  007\r\n" -> addr 0 = 511, addr 1 = 7; repeated separators skipped; done pulses.
- 1x1, "512 ":
  - Without the macro -> error = 1, no wr_en, busy = 0.
  - With MATRIX_PARSER_SATURATE_EN -> addr 0 = 511, done.
- 2x2, "3 x" -> addr 0 = 3 written, then error = 1 on 'x'. Start held high -> stays in WAIT_REL. Start low then high -> error clears and a new parse begins at addr 0.
- matrix_col = 0 with start -> error = 1 immediately, busy never asserted, no writes.
- 3x3, rst_n pulsed low after "1 2 " -> busy = 0, wr_en = 0. Following bytes are ignored until a new start.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, widths and parser state encoding for the matrix receive path.
package matrix_pkg;

  localparam int unsigned DATA_W  = 9;
  localparam int unsigned MAX_DIM = 5;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DIM_W   = 3;
  localparam int unsigned ACC_W   = 13;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [DATA_W-1:0] DATA_MAX = '1;

  localparam logic [BYTE_W-1:0] ASCII_0     = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_9     = 8'h39;
  localparam logic [BYTE_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [BYTE_W-1:0] ASCII_LF    = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_CR    = 8'h0D;

  typedef enum logic [2:0] {
    PS_IDLE,
    PS_SKIP,
    PS_ACC,
    PS_FIN,
    PS_ERR,
    PS_WAIT_REL
  } parser_state_e;

endpackage

// File: rtl/matrix_parser_if.sv
// Byte stream in from uart_rx and element writes out to matrix storage.
interface matrix_parser_if;
  import matrix_pkg::*;

  logic                rx_valid;
  logic [BYTE_W-1:0]   rx_data;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  modport master (
    input  rx_valid, rx_data,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ascii_decimal_accum.sv
// ASCII byte classifier and decimal accumulator (acc*10 + digit) with overflow detection.
// Optional MATRIX_PARSER_SATURATE_EN: clamp at DATA_MAX instead of flagging overflow.
module ascii_decimal_accum
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              add,
  input  logic [BYTE_W-1:0] data,
  output logic              is_digit_c,
  output logic              is_sep_c,
  output logic              ovf_c,
  output logic [DATA_W-1:0] acc
);

  logic [3:0]        digit;
  logic [ACC_W-1:0]  sum;
  logic              over;
  logic [DATA_W-1:0] acc_d;

  // Classify the byte and form the next accumulator value
  always_comb begin
    is_digit_c = (data >= ASCII_0) && (data <= ASCII_9);
    is_sep_c   = (data == ASCII_SPACE) || (data == ASCII_LF) || (data == ASCII_CR);
    digit      = 4'(data - ASCII_0);
    sum        = ACC_W'(acc) * ACC_W'(10) + ACC_W'(digit);
    over       = sum > ACC_W'(DATA_MAX);
    acc_d      = acc;
`ifdef MATRIX_PARSER_SATURATE_EN
    ovf_c = 1'b0;
    if (clear)     acc_d = '0;
    else if (load) acc_d = DATA_W'(digit);
    else if (add)  acc_d = over ? DATA_MAX : sum[DATA_W-1:0];
`else
    ovf_c = over;
    if (clear)     acc_d = '0;
    else if (load) acc_d = DATA_W'(digit);
    else if (add)  acc_d = over ? acc : sum[DATA_W-1:0];
`endif
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= acc_d;
  end

endmodule

// File: rtl/matrix_parser.sv
// Parses whitespace-separated decimal numbers from a UART byte stream into
// row-major matrix storage. Optional MATRIX_PARSER_SATURATE_EN clamps
// oversized numbers at 511 instead of raising error.
module matrix_parser
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] matrix_row,
  input  logic [DIM_W-1:0] matrix_col,
  output logic             busy,
  output logic             done,
  output logic             error,
  matrix_parser_if.master  bus
);

  parser_state_e     state_q, state_d;
  logic [DIM_W-1:0]  r_q, r_d, c_q, c_d, row_q, row_d, col_q, col_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              acc_clear, acc_load, acc_add;
  logic              is_digit, is_sep, is_ovf;
  logic [DATA_W-1:0] acc_val;

  ascii_decimal_accum u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (acc_clear),
    .load       (acc_load),
    .add        (acc_add),
    .data       (bus.rx_data),
    .is_digit_c (is_digit),
    .is_sep_c   (is_sep),
    .ovf_c      (is_ovf),
    .acc        (acc_val)
  );

  // Next state, element counters and registered output values
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    row_d     = row_q;
    col_d     = col_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    unique case (state_q)
      PS_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          r_d       = '0;
          c_d       = '0;
          acc_clear = 1'b1;
          error_d   = 1'b0;
          row_d     = matrix_row;
          col_d     = matrix_col;
          if ((matrix_row == '0) || (matrix_row > DIM_W'(MAX_DIM)) ||
              (matrix_col == '0) || (matrix_col > DIM_W'(MAX_DIM))) begin
            state_d = PS_ERR;
          end else begin
            busy_d  = 1'b1;
            state_d = PS_SKIP;
          end
        end
      end
      PS_SKIP: begin
        if (bus.rx_valid) begin
          if (is_digit) begin
            acc_load = 1'b1;
            state_d  = PS_ACC;
          end else if (!is_sep) begin
            state_d = PS_ERR;
          end
        end
      end
      PS_ACC: begin
        if (bus.rx_valid) begin
          if (is_digit) begin
            if (is_ovf) state_d = PS_ERR;
            else        acc_add = 1'b1;
          end else if (is_sep) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(8'(r_q) * 8'(col_q) + 8'(c_q));
            wr_data_d = acc_val;
            state_d   = PS_SKIP;
            if (c_q == DIM_W'(col_q - DIM_W'(1))) begin
              c_d = '0;
              r_d = DIM_W'(r_q + DIM_W'(1));
              if (r_q == DIM_W'(row_q - DIM_W'(1))) state_d = PS_FIN;
            end else begin
              c_d = DIM_W'(c_q + DIM_W'(1));
            end
          end else begin
            state_d = PS_ERR;
          end
        end
      end
      PS_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = PS_WAIT_REL;
      end
      PS_ERR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = PS_WAIT_REL;
      end
      PS_WAIT_REL: begin
        if (!start) state_d = PS_IDLE;
      end
      default: state_d = PS_IDLE;
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PS_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      row_q     <= row_d;
      col_q     <= col_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_matrix_parser.sv
// Randomized and directed bench for matrix_parser against a token-level reference model.
module tb_matrix_parser;
  import matrix_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] matrix_row = '0;
  logic [2:0] matrix_col = '0;
  logic       busy, done, error;

  matrix_parser_if bus ();

  matrix_parser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .matrix_row (matrix_row),
    .matrix_col (matrix_col),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: collects writes, done pulses and busy activity
  int got_addr[$], got_data[$], got_cyc[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0;
  bit busy_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.wr_en === 1'b1) begin
      got_addr.push_back(int'(bus.wr_addr));
      got_data.push_back(int'(bus.wr_data));
      got_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_seen = 1;
  end

  task automatic clear_mon();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = 0; busy_seen = 0;
  endtask

  // Reference model: tokenises the byte string into numbers with linear indices
  int exp_addr[$], exp_data[$];
  int exp_done, exp_err, exp_busy, exp_busy_seen;

  task automatic model(input int row, input int col, input string s);
    int idx, val, d;
    bit innum;
    byte ch;
    exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_err = 0; exp_busy = 0; exp_busy_seen = 1;
    if (row < 1 || row > 5 || col < 1 || col > 5) begin
      exp_err = 1; exp_busy_seen = 0; return;
    end
    idx = 0; val = 0; innum = 0;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      if (ch >= "0" && ch <= "9") begin
        d = int'(ch) - 48;
        if (!innum) begin
          val = d; innum = 1;
        end else begin
          val = val * 10 + d;
          if (val > 511) begin
`ifdef MATRIX_PARSER_SATURATE_EN
            val = 511;
`else
            exp_err = 1; return;
`endif
          end
        end
      end else if (ch == " " || ch == 8'h0A || ch == 8'h0D) begin
        if (innum) begin
          exp_addr.push_back(idx); exp_data.push_back(val);
          idx++; innum = 0;
          if (idx == row * col) begin exp_done = 1; return; end
        end
      end else begin
        exp_err = 1; return;
      end
    end
    exp_busy = 1;
  endtask

  task automatic drive_bytes(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = s[i];
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, ".nwr"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s.data%0d", tag, i), got_data[i], exp_data[i]);
    end
    check({tag, ".done"}, done_cnt, exp_done);
    check({tag, ".error"}, int'(error), exp_err);
    check({tag, ".busy"}, int'(busy), exp_busy);
    check({tag, ".busy_seen"}, int'(busy_seen), exp_busy_seen);
    if (exp_done && got_cyc.size() > 0)
      check({tag, ".done_lat"}, done_cyc - got_cyc[got_cyc.size()-1], 1);
  endtask

  task automatic run_case(input string tag, input int row, input int col,
                          input string s, input bit gaps, input bit keep_start);
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    matrix_row = 3'(row);
    matrix_col = 3'(col);
    start = 1'b1;
    @(negedge clk);
    check({tag, ".err_clr"}, int'(error), 0);
    drive_bytes(s, gaps);
    repeat (4) @(negedge clk);
    model(row, col, s);
    compare(tag);
    if (!keep_start) begin
      start = 1'b0;
      repeat (2) @(negedge clk);
      if (exp_busy) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  function automatic string rand_stream(input int row, input int col);
    string s;
    int v, nsep;
    int unsigned k;
    s = "";
    for (int e = 0; e < row * col; e++) begin
      v = (($urandom % 8) == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 511));
      if (($urandom % 5) == 0) s = {s, "0"};
      s = {s, $sformatf("%0d", v)};
      if (($urandom % 25) == 0) s = {s, "x"};
      nsep = int'($urandom_range(1, 3));
      for (int j = 0; j < nsep; j++) begin
        k = $urandom % 3;
        s = {s, (k == 0) ? " " : ((k == 1) ? "\n" : "\r")};
      end
    end
    if (($urandom % 4) == 0) s = {s, "9 8 "};
    return s;
  endfunction

  initial begin
    int row, col;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    repeat (3) @(negedge clk);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.error", int'(error), 0);
    check("rst.wr_en", int'(bus.wr_en), 0);
    check("rst.wr_addr", int'(bus.wr_addr), 0);
    check("rst.wr_data", int'(bus.wr_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_case("d2x3", 2, 3, "1 2 3\n4 5 6\n", 1'b0, 1'b0);
    run_case("d1x2", 1, 2, "511  007\r\n", 1'b0, 1'b0);
    run_case("d512", 1, 1, "512 ", 1'b0, 1'b0);
    run_case("dcol0", 2, 0, "1 2 ", 1'b0, 1'b0);

    // Error with start held: WAIT_REL must swallow later bytes
    run_case("dillegal", 2, 2, "3 x", 1'b0, 1'b1);
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    drive_bytes("5 6 7 8 ", 1'b0);
    repeat (3) @(negedge clk);
    check("hold.nwr", got_addr.size(), 0);
    check("hold.error", int'(error), 1);
    check("hold.done", done_cnt, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    run_case("drestart", 1, 1, "7 ", 1'b0, 1'b0);

    // Reset mid-parse: no partial write, later bytes ignored without start
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    matrix_row = 3'd3; matrix_col = 3'd3; start = 1'b1;
    @(negedge clk);
    drive_bytes("1 2 ", 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("rstmid.busy", int'(busy), 0);
    check("rstmid.wr_en", int'(bus.wr_en), 0);
    check("rstmid.error", int'(error), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_bytes("3 4 ", 1'b0);
    repeat (3) @(negedge clk);
    check("rstmid.nwr", got_addr.size(), 2);
    check("rstmid.busy2", int'(busy), 0);
    check("rstmid.done", done_cnt, 0);

    for (int t = 0; t < 40; t++) begin
      row = (($urandom % 10) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 5));
      col = (($urandom % 10) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 5));
      run_case($sformatf("rnd%0d", t), row, col, rand_stream(row, col), t[0], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
